// File: rtl/alu_ctrl_sequencer.sv
// Multi-cycle Tiny RISC decode/sequencing unit driving the ALU controls.
// Optional: define ALU_CTRL_ILLEGAL_TRAP_EN to pulse illegal for ops 21..31.
module alu_ctrl_sequencer #(
  parameter int DIV_CYCLES = 4,
  parameter int MUL_CYCLES = 2,
  parameter int ALU_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  input  logic [31:0] ret_addr,
  input  logic        alu_eq,
  input  logic        alu_gt,
  input  logic        mem_ack,
  output logic        isAdd,
  output logic        isSub,
  output logic        isMul,
  output logic        isDiv,
  output logic        isMod,
  output logic        isCmp,
  output logic        isAnd,
  output logic        isOr,
  output logic        isNot,
  output logic        isMov,
  output logic        isLsl,
  output logic        isLsr,
  output logic        isAsr,
  output logic        isImmediate,
  output logic [31:0] imm,
  output logic [3:0]  rd_addr,
  output logic [3:0]  rs1_addr,
  output logic [3:0]  rs2_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        wb_en,
  output logic        wb_pc_sel,
  output logic        flagE,
  output logic        flagGt,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0] r_inst;
  logic [31:0] r_pc;
  logic [3:0]  r_cnt;
  logic [12:0] r_strobe;
  logic        r_isimm;
  logic        r_pcsel;
  logic        r_flag_e;
  logic        r_flag_gt;
  logic [31:0] r_imm;
  logic [31:0] r_target;
  logic [3:0]  r_rd;
  logic [3:0]  r_rs1;
  logic [3:0]  r_rs2;

  logic [4:0]  w_op;
  logic [20:0] w_dec;
  logic [15:0] w_imm16;
  logic [31:0] w_imm;
  logic [31:0] w_target;
  logic [3:0]  w_cnt;
  logic [12:0] w_strobe;
  logic        w_ldst;
  logic        w_ill;
  logic        w_skip;
  logic        w_wb;
  logic        w_taken;

  // r_inst holds the accepted word until retire, so decode is
  // recomputed from it in every state instead of being registered.
  assign w_op     = r_inst[31:27];
  assign w_dec    = 21'd1 << w_op;
  assign w_imm16  = r_inst[15:0];
  assign w_ldst   = w_dec[14] | w_dec[15];
  assign w_ill    = w_op > 5'd20;
  assign w_skip   = w_dec[13] | (|w_dec[20:16]) | w_ill;
  assign w_wb     = (|w_dec[12:0]) | w_dec[14] | w_dec[19];
  assign w_strobe = w_ldst ? 13'd1 : w_dec[12:0];

  assign w_taken = (|w_dec[20:18])
                 | (w_dec[16] & r_flag_e)
                 | (w_dec[17] & r_flag_gt);

  assign w_target = w_dec[20] ? ret_addr :
    r_pc + {{3{r_inst[26]}}, r_inst[26:0], 2'b00};

  always_comb begin
    w_imm = {{16{w_imm16[15]}}, w_imm16};
    unique case (1'b1)
      r_inst[17:16] == 2'b01: w_imm = {16'h0, w_imm16};
      r_inst[17:16] == 2'b10: w_imm = {w_imm16, 16'h0};
      default: ;
    endcase
  end

  always_comb begin
    w_cnt = 4'(ALU_CYCLES);
    unique case (1'b1)
      w_dec[3] | w_dec[4]: w_cnt = 4'(DIV_CYCLES);
      w_dec[2]:            w_cnt = 4'(MUL_CYCLES);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (inst_valid) w_next = S_DECODE;
      S_DECODE: w_next = w_skip ? S_WB : S_EXEC;
      S_EXEC:   if (r_cnt <= 4'd1) w_next = w_ldst ? S_MEM : S_WB;
      S_MEM:    if (mem_ack) w_next = S_WB;
      S_WB:     w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst    <= '0;
      r_pc      <= '0;
      r_cnt     <= '0;
      r_strobe  <= '0;
      r_isimm   <= 1'b0;
      r_pcsel   <= 1'b0;
      r_imm     <= '0;
      r_target  <= '0;
      r_rd      <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_flag_e  <= 1'b0;
      r_flag_gt <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (inst_valid) begin
            r_inst <= inst;
            r_pc   <= pc;
          end
        end
        S_DECODE: begin
          r_cnt    <= w_skip ? 4'd0 : w_cnt;
          r_strobe <= w_strobe;
          r_isimm  <= !w_skip & (w_ldst | r_inst[26]);
          r_imm    <= w_imm;
          r_rd     <= w_dec[19] ? 4'hF : r_inst[25:22];
          r_rs1    <= r_inst[21:18];
          r_rs2    <= r_inst[17:14];
          r_pcsel  <= w_dec[19];
          r_target <= w_target;
        end
        S_EXEC: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt <= 4'd1 && w_dec[5]) begin
            r_flag_e  <= alu_eq;
            r_flag_gt <= alu_gt;
          end
        end
        S_WB: begin
          r_strobe <= '0;
          r_isimm  <= 1'b0;
          r_pcsel  <= 1'b0;
          r_imm    <= '0;
          r_target <= '0;
          r_rd     <= '0;
          r_rs1    <= '0;
          r_rs2    <= '0;
        end
        default: ;
      endcase
    end
  end

  assign inst_ready = r_state == S_IDLE;
  assign done       = r_state == S_WB;

  assign {isAsr, isLsr, isLsl, isMov, isNot, isOr, isAnd,
          isCmp, isMod, isDiv, isMul, isSub, isAdd} =
    (r_state == S_EXEC) ? r_strobe : 13'd0;

  assign isImmediate   = r_isimm;
  assign imm           = r_imm;
  assign rd_addr       = r_rd;
  assign rs1_addr      = r_rs1;
  assign rs2_addr      = r_rs2;
  assign mem_rd        = (r_state == S_MEM) & w_dec[14];
  assign mem_wr        = (r_state == S_MEM) & w_dec[15];
  assign wb_en         = done & w_wb;
  assign wb_pc_sel     = r_pcsel;
  assign flagE         = r_flag_e;
  assign flagGt        = r_flag_gt;
  assign branch_taken  = done & w_taken;
  assign branch_target = r_target;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  assign illegal = done & w_ill;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// Randomized bench for alu_ctrl_sequencer against a per-instruction
// timeline model derived from the opcode rules.
`timescale 1ns/1ps
module tb_alu_ctrl_sequencer;

  localparam int DIV_C = 4;
  localparam int MUL_C = 2;
  localparam int ALU_C = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] ret_addr;
  logic        alu_eq;
  logic        alu_gt;
  logic        mem_ack;
  logic        isAdd, isSub, isMul, isDiv, isMod, isCmp, isAnd;
  logic        isOr, isNot, isMov, isLsl, isLsr, isAsr;
  logic        isImmediate;
  logic [31:0] imm;
  logic [3:0]  rd_addr, rs1_addr, rs2_addr;
  logic        mem_rd, mem_wr, wb_en, wb_pc_sel;
  logic        flagE, flagGt, branch_taken;
  logic [31:0] branch_target;
  logic        done, illegal;

  logic [12:0] w_str;
  assign w_str = {isAsr, isLsr, isLsl, isMov, isNot, isOr, isAnd,
                  isCmp, isMod, isDiv, isMul, isSub, isAdd};

  always #5 clk = ~clk;

  alu_ctrl_sequencer #(
    .DIV_CYCLES(DIV_C),
    .MUL_CYCLES(MUL_C),
    .ALU_CYCLES(ALU_C)
  ) dut (
    .clk(clk), .rst(rst),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .pc(pc), .ret_addr(ret_addr),
    .alu_eq(alu_eq), .alu_gt(alu_gt), .mem_ack(mem_ack),
    .isAdd(isAdd), .isSub(isSub), .isMul(isMul), .isDiv(isDiv),
    .isMod(isMod), .isCmp(isCmp), .isAnd(isAnd), .isOr(isOr),
    .isNot(isNot), .isMov(isMov), .isLsl(isLsl), .isLsr(isLsr),
    .isAsr(isAsr), .isImmediate(isImmediate), .imm(imm),
    .rd_addr(rd_addr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .wb_en(wb_en),
    .wb_pc_sel(wb_pc_sel), .flagE(flagE), .flagGt(flagGt),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .done(done), .illegal(illegal)
  );

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  bit trap_en = 1'b1;
`else
  bit trap_en = 1'b0;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  bit m_fe   = 1'b0;
  bit m_fg   = 1'b0;

  task automatic chk(input string tag, input logic [95:0] got,
                     input logic [95:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int m_cnt(int op);
    if (op == 3 || op == 4) return DIV_C;
    if (op == 2) return MUL_C;
    return ALU_C;
  endfunction

  function automatic logic [12:0] m_strobe(int op);
    if (op == 14 || op == 15) return 13'd1;
    if (op <= 12) return 13'd1 << op;
    return 13'd0;
  endfunction

  function automatic bit m_wb(int op);
    return op <= 12 || op == 14 || op == 19;
  endfunction

  function automatic logic [31:0] m_imm(logic [31:0] w);
    logic [31:0] lo;
    lo = {16'h0, w[15:0]};
    case (w[17:16])
      2'b01:   return lo;
      2'b10:   return lo * 32'h1_0000;
      default: return w[15] ? lo + 32'hFFFF_0000 : lo;
    endcase
  endfunction

  function automatic logic [31:0] m_tgt(logic [31:0] w, logic [31:0] p);
    logic [31:0] o;
    o = {5'd0, w[26:0]};
    if (w[26]) o = o - 32'h0800_0000;
    return p + o * 4;
  endfunction

  task automatic run_inst(input logic [31:0] w, input logic [31:0] p,
                          input int ackd, input bit eq, input bit gt,
                          input bit hold);
    int op, cnt, d, nack, k;
    bit skip, ldst, fe, fg, tk;
    logic [31:0] ra;
    logic [19:0] ev;
    k = 0;
    while (!inst_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("ready_wait", inst_ready, 1'b1);
    op   = int'(w[31:27]);
    cnt  = m_cnt(op);
    skip = op == 13 || op >= 16;
    ldst = op == 14 || op == 15;
    d    = skip ? 2 : cnt + 2 + (ldst ? ackd : 0);
    nack = cnt + 1 + ackd;
    fe   = m_fe;
    fg   = m_fg;
    if (op == 5) begin
      fe = eq;
      fg = gt;
    end
    tk = (op >= 18 && op <= 20) || (op == 16 && m_fe) ||
         (op == 17 && m_fg);
    ra = $urandom;
    inst = w; pc = p; ret_addr = ra;
    alu_eq = eq; alu_gt = gt;
    inst_valid = 1'b1;
    for (int n = 1; n <= d + 1; n++) begin
      @(negedge clk);
      ev = '0;
      if (!skip && n >= 2 && n <= cnt + 1) ev[19:7] = m_strobe(op);
      ev[6] = n == d;
      ev[5] = n == d && m_wb(op);
      ev[4] = op == 14 && n >= cnt + 2 && n <= nack;
      ev[3] = op == 15 && n >= cnt + 2 && n <= nack;
      ev[2] = n == d && tk;
      ev[1] = n == d && op >= 21 && trap_en;
      ev[0] = n == d + 1;
      chk("ctl", {w_str, done, wb_en, mem_rd, mem_wr,
                  branch_taken, illegal, inst_ready}, ev);
      chk("flags", {flagE, flagGt},
          n > cnt + 1 ? {fe, fg} : {m_fe, m_fg});
      if (!skip && n >= 2 && n <= cnt + 1)
        chk("imm", {isImmediate, imm}, {ldst | w[26], m_imm(w)});
      if (n == d) begin
        chk("regs", {rd_addr, rs1_addr, rs2_addr, wb_pc_sel},
            {op == 19 ? 4'hF : w[25:22], w[21:18], w[17:14],
             op == 19});
        if (op >= 16 && op <= 20)
          chk("tgt", branch_target, op == 20 ? ra : m_tgt(w, p));
      end
      if (n == d + 1)
        chk("clr", {imm, rd_addr, rs1_addr, rs2_addr, isImmediate,
                    wb_pc_sel, branch_target}, 96'd0);
      if (n == 1 && !hold) inst_valid = 1'b0;
      mem_ack = ldst && n == nack;
    end
    m_fe = fe;
    m_fg = fg;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic [4:0]  op;
    rst = 1'b1; inst_valid = 1'b0; inst = '0; pc = '0;
    ret_addr = '0; alu_eq = 1'b0; alu_gt = 1'b0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ctl", {w_str, done, wb_en, mem_rd, mem_wr,
                    branch_taken, illegal, inst_ready}, 20'd1);
    chk("rst_regs", {imm, rd_addr, rs1_addr, rs2_addr, isImmediate,
                     wb_pc_sel, branch_target, flagE, flagGt}, 96'd0);

    run_inst(32'h004C_C000, 32'h0, 1, 1'b0, 1'b0, 1'b0);
    run_inst(32'h4D00_FFFF, 32'h4, 1, 1'b0, 1'b0, 1'b0);
    run_inst(32'h4D01_FFFF, 32'h8, 1, 1'b0, 1'b0, 1'b1);
    run_inst(32'h4D02_FFFF, 32'hC, 1, 1'b0, 1'b0, 1'b0);
    run_inst(32'h1800_0000, 32'h10, 1, 1'b0, 1'b0, 1'b1);
    run_inst(32'h2800_0000, 32'hF0, 1, 1'b1, 1'b0, 1'b0);
    run_inst(32'h8000_0003, 32'h100, 1, 1'b0, 1'b0, 1'b0);
    run_inst(32'h8800_0003, 32'h104, 1, 1'b0, 1'b0, 1'b0);
    run_inst(32'h7084_0010, 32'h108, 3, 1'b0, 1'b0, 1'b0);

    inst_valid = 1'b0;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("ack_idle", {w_str, done, wb_en, mem_rd, mem_wr,
                     branch_taken, illegal, inst_ready}, 20'd1);

    run_inst(32'hA800_0000, 32'h200, 1, 1'b0, 1'b0, 1'b0);
    run_inst(32'h2800_0000, 32'h204, 1, 1'b1, 1'b1, 1'b0);

    inst = 32'h1800_0000;
    inst_valid = 1'b1;
    @(negedge clk);
    inst_valid = 1'b0;
    @(negedge clk);
    chk("div_mid", isDiv, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_fe = 1'b0;
    m_fg = 1'b0;
    chk("rst_abort", {w_str, flagE, flagGt, done, wb_en, inst_ready},
        {13'd0, 4'b0000, 1'b1});
    repeat (4) begin
      @(negedge clk);
      chk("rst_quiet", {done, wb_en, inst_ready, w_str},
          {3'b001, 13'd0});
    end

    for (int i = 0; i < 300; i++) begin
      r  = $urandom;
      op = 5'($urandom_range(0, 31));
      run_inst({op, r[26:0]}, $urandom, $urandom_range(1, 4),
               1'($urandom), 1'($urandom), 1'($urandom));
    end
    inst_valid = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
